// File: rtl/ni_packetizer.sv
// Network-interface transmitter: turns a packet request plus a payload word stream into
// header/body/tail flits for a router local input port. Optional macro NI_PARITY_EN.
module ni_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int AXIS       = 4,
  parameter int MAX_LEN    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXIS-1:0]       cur_addr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AXIS-1:0]       req_dst,
  input  logic [11:0]           req_len,
  input  logic [DATA_WIDTH-4:0] pl_data,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic                  pkt_done,
  output logic                  len_err
);

`ifdef NI_PARITY_EN
  localparam int SEQ_W = DATA_WIDTH - 16 - 2 * AXIS;
`else
  localparam int SEQ_W = DATA_WIDTH - 15 - 2 * AXIS;
`endif

  localparam logic [2:0]       ID_HEAD   = 3'b001;
  localparam logic [2:0]       ID_BODY   = 3'b010;
  localparam logic [2:0]       ID_TAIL   = 3'b100;
  localparam logic [11:0]      MAX_LEN_C = 12'(MAX_LEN);
  localparam logic [SEQ_W-1:0] SEQ_ONE   = {{(SEQ_W - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [11:0]             rem_q, rem_d;
  logic [SEQ_W-1:0]        seq_q, seq_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    pkt_done_q, pkt_done_d;
  logic                    len_err_q, len_err_d;
  logic                    busy_q, busy_d;

  logic                    xfer_s;
  logic                    out_free_s;
  logic                    tail_xfer_s;
  logic                    req_ready_s;
  logic                    pl_ready_s;
  logic                    len_bad_s;
  logic [11:0]             len_p1_s;

  // Bit 0 carries even parity over the rest of the flit when parity is enabled.
  function automatic logic [DATA_WIDTH-1:0] add_parity(input logic [DATA_WIDTH-1:0] flit);
    logic [DATA_WIDTH-1:0] f;
    f = flit;
`ifdef NI_PARITY_EN
    f[0] = ^f[DATA_WIDTH-1:1];
`endif
    return f;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] make_header(
    input logic [11:0]      len_p1,
    input logic [AXIS-1:0]  dst,
    input logic [AXIS-1:0]  src,
    input logic [SEQ_W-1:0] seq
  );
`ifdef NI_PARITY_EN
    return add_parity({ID_HEAD, len_p1, dst, src, seq, 1'b0});
`else
    return add_parity({ID_HEAD, len_p1, dst, src, seq});
`endif
  endfunction

  assign xfer_s      = valid_q && ready_in;
  assign out_free_s  = !valid_q || ready_in;
  assign tail_xfer_s = xfer_s && (state_q == BODY) && (data_q[DATA_WIDTH-1:DATA_WIDTH-3] == ID_TAIL);
  assign len_bad_s   = (req_len == 12'd0) || (req_len > MAX_LEN_C);
  assign len_p1_s    = req_len + 12'd1;

  // Next-state, handshake and output-register load logic.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    seq_d       = seq_q;
    valid_d     = valid_q;
    data_d      = data_q;
    pkt_done_d  = 1'b0;
    len_err_d   = 1'b0;
    req_ready_s = 1'b0;
    pl_ready_s  = 1'b0;

    if (xfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      IDLE: begin
        req_ready_s = out_free_s;
      end
      HEAD: begin
        pl_ready_s = out_free_s && (rem_q != 12'd0);
        if (xfer_s) begin
          seq_d   = seq_q + SEQ_ONE;
          state_d = BODY;
        end else begin
          state_d = HEAD;
        end
      end
      BODY: begin
        pl_ready_s = out_free_s && (rem_q != 12'd0);
        // The tail handshake frees the register, so a new request can load its header now.
        if (tail_xfer_s) begin
          pkt_done_d  = 1'b1;
          state_d     = IDLE;
          req_ready_s = 1'b1;
        end else begin
          state_d = BODY;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (req_valid && req_ready_s) begin
      if (len_bad_s) begin
        len_err_d = 1'b1;
      end else begin
        data_d  = make_header(len_p1_s, req_dst, cur_addr, seq_q);
        valid_d = 1'b1;
        rem_d   = req_len;
        state_d = HEAD;
      end
    end else begin
      len_err_d = 1'b0;
    end

    if (pl_valid && pl_ready_s) begin
      data_d  = add_parity({(rem_q == 12'd1) ? ID_TAIL : ID_BODY, pl_data});
      valid_d = 1'b1;
      rem_d   = rem_q - 12'd1;
      state_d = BODY;
    end else begin
      rem_d = rem_d;
    end

    busy_d = (state_d != IDLE) || valid_d;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= 12'd0;
      seq_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      pkt_done_q <= 1'b0;
      len_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      seq_q      <= seq_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      pkt_done_q <= pkt_done_d;
      len_err_q  <= len_err_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ready = req_ready_s;
  assign pl_ready  = pl_ready_s;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign busy      = busy_q;
  assign pkt_done  = pkt_done_q;
  assign len_err   = len_err_q;

endmodule
